// File: rtl/cnt_sched.sv
// cnt_sched: round-robin scheduler that shares one M-bit down counter between NREQ requesters.
//
// A requester raises req[i] (level, held until done) with its countdown length on
// len[i*M +: M]. The scheduler picks the next requester round-robin, loads the counter
// with that length, decrements it once every PRESC clocks and pulses done[i] once the
// count has reached zero.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   req   in   [NREQ]    per-requester request level
//   len   in   [NREQ*M]  packed countdown lengths, sampled only in LOAD
//   gnt   out  [NREQ]    one-hot grant, LOAD through DONE; zero while idle
//   busy  out            high in every state except IDLE
//   done  out  [NREQ]    one-cycle completion pulse to the granted requester
//   q     out  [M]       current counter value
//   tick  out            high in a COUNT cycle where q decrements
//
// Build option:
//   CNT_SCHED_ABORT_EN  when defined, dropping req of the granted requester during LOAD or
//                       COUNT abandons the grant (back to IDLE, no done pulse, q frozen).
//                       When undefined, a grant always runs to DONE.

module cnt_sched #(
  parameter int unsigned M     = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PRESC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*M-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [NREQ-1:0]   done,
  output logic [M-1:0]      q,
  output logic              tick
);

  localparam int unsigned IW = $clog2(NREQ);
  // A 1-bit prescaler still exists when PRESC == 1; it just never leaves zero.
  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(PRESC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCount,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   w_q, w_d;        // index of the current grant owner
  logic [IW-1:0]   last_q, last_d;  // round-robin pointer: most recently granted index
  logic [M-1:0]    q_q, q_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [IW-1:0]   winner;
  logic            abort;
  logic            tick_c;

  // Round-robin search: first asserted request strictly after last_q, wrapping modulo NREQ.
  // The offset runs to NREQ so the previous owner is considered last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      int idx;
      idx = (int'(last_q) + k) % int'(NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    abort = 1'b0;
`ifdef CNT_SCHED_ABORT_EN
    abort = ((state_q == StLoad) || (state_q == StCount)) && !req[w_q];
`endif
    // Zero is checked before the tick, so q never wraps. An abort suppresses the
    // decrement, hence the tick as well.
    tick_c = (state_q == StCount) && (q_q != '0) && (presc_q == PrescMax) && !abort;
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    last_d  = last_q;
    q_d     = q_q;
    presc_d = presc_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          w_d     = winner;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // The pointer moves even when the grant is aborted here.
        last_d = w_q;
        if (abort) begin
          state_d = StIdle;
        end else begin
          q_d     = len[int'(w_q)*M +: M];
          presc_d = '0;
          state_d = StCount;
        end
      end
      StCount: begin
        if (abort) begin
          state_d = StIdle;
        end else if (q_q == '0) begin
          state_d = StDone;
        end else if (tick_c) begin
          q_d     = q_q - 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Grant-side outputs are registered from the next state so they line up with it.
    gnt_d  = '0;
    done_d = '0;
    busy_d = (state_d != StIdle);
    if (state_d != StIdle) begin
      gnt_d[w_d] = 1'b1;
    end
    if (state_d == StDone) begin
      done_d[w_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      w_q     <= '0;
      last_q  <= IW'(NREQ - 1);
      q_q     <= '0;
      presc_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      last_q  <= last_d;
      q_q     <= q_d;
      presc_q <= presc_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign q    = q_q;
  assign tick = tick_c;

endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched: one instance with PRESC=1 and one with PRESC=4.

module tb_cnt_sched;

  localparam int unsigned M    = 4;
  localparam int unsigned NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req,  gnt,  done;
  logic [NREQ-1:0]   req4, gnt4, done4;
  logic [NREQ*M-1:0] len,  len4;
  logic              busy, tick, busy4, tick4;
  logic [M-1:0]      q, q4;

  int checks   = 0;
  int failures = 0;

  int ticks, dcyc, q6, t4c, t5c, ngr, onehot_bad;
  int order[5];

  cnt_sched #(.M(M), .NREQ(NREQ), .PRESC(1)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .busy (busy),
    .done (done),
    .q    (q),
    .tick (tick)
  );

  cnt_sched #(.M(M), .NREQ(NREQ), .PRESC(4)) u_dut_p4 (
    .clk  (clk),
    .rst  (rst),
    .req  (req4),
    .len  (len4),
    .gnt  (gnt4),
    .busy (busy4),
    .done (done4),
    .q    (q4),
    .tick (tick4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int idx, input logic [M-1:0] v);
    len[idx*M +: M] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    len  = '0;
    req4 = '0;
    len4 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check_eq("rst_gnt",  32'(gnt),  32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_q",    32'(q),    32'h0);
    check_eq("rst_tick", 32'(tick), 32'h0);
    check_eq("rst_busy4", 32'(busy4), 32'h0);
    rst = 1'b0;

    // T1: single request, len=3, PRESC=1; later len change must not matter
    set_len(0, 4'd3);
    req = 4'b0001;
    check_eq("t1_idle_gnt", 32'(gnt), 32'h0);
    step();
    check_eq("t1_load_gnt",  32'(gnt),  32'h1);
    check_eq("t1_load_busy", 32'(busy), 32'h1);
    step();
    for (int k = 0; k < 4; k++) begin
      check_eq("t1_q",    32'(q),    32'(3 - k));
      check_eq("t1_tick", 32'(tick), 32'(k < 3));
      check_eq("t1_done", 32'(done), 32'h0);
      if (k == 0) set_len(0, 4'd9);
      step();
    end
    check_eq("t1_done_pulse", 32'(done), 32'h1);
    check_eq("t1_done_gnt",   32'(gnt),  32'h1);
    req = '0;
    step();
    check_eq("t1_idle_busy", 32'(busy), 32'h0);
    check_eq("t1_idle_gnt2", 32'(gnt),  32'h0);
    check_eq("t1_idle_done", 32'(done), 32'h0);

    // T2: len=0 on requester 2
    set_len(2, 4'd0);
    req = 4'b0100;
    step();
    check_eq("t2_load_gnt", 32'(gnt), 32'h4);
    step();
    check_eq("t2_cnt_q",    32'(q),    32'h0);
    check_eq("t2_cnt_tick", 32'(tick), 32'h0);
    check_eq("t2_cnt_done", 32'(done), 32'h0);
    step();
    check_eq("t2_done", 32'(done), 32'h4);
    req = '0;
    step();
    check_eq("t2_idle_busy", 32'(busy), 32'h0);

    // T3: PRESC=4, len=2 -> LOAD at 1, COUNT 2..10, DONE at 11, ticks at 5 and 9
    len4  = 16'h0002;
    req4  = 4'b0001;
    ticks = 0;
    dcyc  = -1;
    q6    = -1;
    t4c   = -1;
    t5c   = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 4) t4c = int'(tick4);
      if (n == 5) t5c = int'(tick4);
      if (n == 6) q6 = int'(q4);
      ticks += int'(tick4);
      if (done4 != '0) begin
        dcyc = n;
        break;
      end
    end
    check_eq("t3_done_cycle", 32'(dcyc),  32'd11);
    check_eq("t3_done_val",   32'(done4), 32'h1);
    check_eq("t3_ticks",      32'(ticks), 32'd2);
    check_eq("t3_tick_c4",    32'(t4c),   32'd0);
    check_eq("t3_tick_c5",    32'(t5c),   32'd1);
    check_eq("t3_q_c6",       32'(q6),    32'd1);
    req4 = '0;
    step();

    // T4: round robin from a fresh reset, all requesting, all len=1
    rst = 1'b1;
    step();
    rst = 1'b0;
    len = 16'h1111;
    req = 4'b1111;
    ngr = 0;
    onehot_bad = 0;
    for (int n = 0; n < 60 && ngr < 5; n++) begin
      step();
      if ($countones(gnt) > 1) onehot_bad++;
      if (done != '0) begin
        check_eq("t4_done_gnt", 32'(done), 32'(gnt));
        order[ngr] = $clog2(done);
        ngr++;
        if (ngr == 5) req = '0;
      end
    end
    check_eq("t4_grants", 32'(ngr), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_order", 32'(order[i]), 32'(i % 4));
    end
    check_eq("t4_onehot", 32'(onehot_bad), 32'd0);
    step();
    check_eq("t4_idle_busy", 32'(busy), 32'h0);

    // T5a: reset during COUNT with q=5, then requester 2 alone
    set_len(1, 4'd7);
    req = 4'b0010;
    repeat (4) step();
    check_eq("t5_q5",  32'(q),   32'd5);
    check_eq("t5_gnt", 32'(gnt), 32'h2);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_q",    32'(q),    32'h0);
    check_eq("t5_rst_gnt",  32'(gnt),  32'h0);
    check_eq("t5_rst_busy", 32'(busy), 32'h0);
    check_eq("t5_rst_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    check_eq("t5_rst_done2", 32'(done), 32'h0);
    rst = 1'b0;
    req = 4'b0100;
    set_len(2, 4'd1);
    step();
    check_eq("t5_regrant", 32'(gnt), 32'h4);
    repeat (3) step();
    check_eq("t5_done", 32'(done), 32'h4);
    req = '0;
    step();

    // T5b: pointer restarts at NREQ-1 after a mid-count reset (last was 2)
    set_len(2, 4'd6);
    req = 4'b0100;
    repeat (3) step();
    check_eq("t5b_q5", 32'(q), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1010;
    set_len(1, 4'd1);
    set_len(3, 4'd1);
    step();
    check_eq("t5b_ptr_gnt", 32'(gnt), 32'h2);
    repeat (3) step();
    check_eq("t5b_done", 32'(done), 32'h2);
    req = '0;
    step();

    // T6: requester 1 drops req at q=4
    set_len(1, 4'd6);
    req = 4'b0010;
    repeat (4) step();
    check_eq("t6_q4", 32'(q), 32'd4);
    req = '0;
`ifdef CNT_SCHED_ABORT_EN
    step();
    check_eq("t6_abort_busy", 32'(busy), 32'h0);
    check_eq("t6_abort_gnt",  32'(gnt),  32'h0);
    check_eq("t6_abort_q",    32'(q),    32'd4);
    dcyc = 0;
    for (int n = 0; n < 8; n++) begin
      if (done != '0) dcyc++;
      step();
    end
    check_eq("t6_abort_nodone", 32'(dcyc), 32'd0);
`else
    dcyc = -1;
    for (int n = 5; n <= 24; n++) begin
      step();
      if (done != '0) begin
        dcyc = n;
        break;
      end
    end
    check_eq("t6_done_cycle", 32'(dcyc), 32'd9);
    check_eq("t6_done_val",   32'(done), 32'h2);
    step();
`endif
    check_eq("t6_final_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
